interboard_tx_sched: RTL and testbench
======================================

Name: interboard_tx_sched

Overview:
Schedules the single interboard transmit link between several requesters, e.g. the game master FSM and the menu/reset controller.
- Each requester gets a one-entry message slot.
- Pending slots are granted round-robin.
- One message at a time is issued to the link, and the scheduler waits for the link's ready/ack before freeing the slot.
- It sits between the game-level controllers and the interboard transmitter, replacing direct ctrl_en/ctrl_msg_type/ctrl_number wiring.

Parameters:
- NUM_REQ, 2, number of requesters; index 0 is the game master.
- GAP_CYC, 4, idle cycles enforced between consecutive link messages (0 allowed).
- TIMEOUT_CYC, 1000000, cycles to wait for tx_ready before a retry (used only with the optional feature).
- MAX_RETRY, 3, re-issues before a message is abandoned (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- interboard_rst  in  1  synchronous, active-high; same effect as rst.
- req_en  in  NUM_REQ  per-requester one-cycle message strobe.
- req_msg_type  in  3*NUM_REQ  message type per requester (message_macro.v encodings), requester i at [3i+2:3i].
- req_number  in  5*NUM_REQ  payload number per requester, requester i at [5i+4:5i].
- req_busy  out  NUM_REQ  slot i holds a pending or in-flight message.
- req_done  out  NUM_REQ  one-cycle pulse when requester i's message is acked.
- req_drop  out  NUM_REQ  one-cycle pulse when req_en[i] is refused (slot full), or when a message is abandoned after retries.
- tx_en  out  1  one-cycle issue strobe to the interboard transmitter.
- tx_msg_type  out  3  message type of the granted slot.
- tx_number  out  5  number of the granted slot.
- tx_ready  in  1  link completion/ack pulse (inter_ready).

Behaviour:
- Reset (rst or interboard_rst): all slots invalid, rr pointer = 0, state IDLE, counters 0, all outputs 0. Reset mid-transfer abandons the message silently; no req_done or req_drop is produced.

Slot write:
- req_en[i] with slot i empty: latch type and number; slot valid next cycle; req_busy[i]=1.
- req_en[i] with slot i full: req_drop[i] pulses the next cycle; slot contents are unchanged.
- Exception: if slot i is being freed in the same cycle (ack or abandon), the new message is accepted.

FSM states: IDLE, ISSUE, WAIT_ACK, GAP.
- IDLE: if any slot is valid, grant the first valid index at or after the rr pointer (wrapping modulo NUM_REQ) and go to ISSUE. Otherwise stay. tx_ready is ignored in IDLE.
- ISSUE: tx_en=1 for exactly one cycle, then go to WAIT_ACK; the timeout counter is cleared.
- WAIT_ACK: tx_msg_type/tx_number remain held. On tx_ready:
  - clear the granted slot;
  - pulse req_done[g] one cycle later (registered);
  - set rr pointer = (g+1) mod NUM_REQ;
  - go to GAP if GAP_CYC>0, else IDLE.
  Without the optional feature, WAIT_ACK waits indefinitely.
- GAP: count GAP_CYC cycles, then go to IDLE. tx_ready is ignored.

Output timing:
- tx_msg_type/tx_number: driven from the granted slot in ISSUE and WAIT_ACK; 0 otherwise.
- Latency: with the scheduler idle, req_en sampled in cycle t gives tx_en high in cycle t+2.
- Back-to-back: after ack in cycle a, the next tx_en occurs in cycle a+GAP_CYC+2.

Fairness and width rules:
- A requester with a pending slot waits at most NUM_REQ-1 other grants.
- The grant index is ceil(log2(NUM_REQ)) bits wide, minimum 1.
- Counters saturate and never wrap.

Optional Feature:
- Macro: INTERBOARD_TX_RETRY_EN.
- With it defined:
  - In WAIT_ACK, the counter reaches TIMEOUT_CYC-1 without tx_ready, so re-enter ISSUE (tx_en re-pulses) and increment the retry count.
  - After MAX_RETRY re-issues plus a further timeout, abandon: clear the slot, pulse req_drop[g], advance the rr pointer, go to GAP.
  - tx_ready arriving in the same cycle as a timeout counts as an ack.
- Without it: no timeout or retry logic; WAIT_ACK is left only on tx_ready or reset.

Decomposition:
- Shared header tx_sched_macro.v holds:
  - the state encodings TXS_IDLE, TXS_ISSUE, TXS_WAIT_ACK, TXS_GAP;
  - requester indices (TXREQ_GAME=0, TXREQ_MENU=1).
- Message-type encodings stay in message_macro.v.
- One sub-module, rr_arbiter:
  - inputs: valid vector and pointer;
  - outputs: grant index and any_valid;
  - purely combinational rotate-priority search, instantiated once.

Test Plan:
- Single message: NUM_REQ=2, GAP_CYC=4; req_en[0] with type=STATE_TURN, number=7 at cycle 10 -> tx_en at cycle 12 with type/number held; tx_ready at cycle 20 -> req_done[0] at cycle 21, req_busy[0]=0, next tx_en no earlier than cycle 26.
- Round-robin: both slots loaded in the same cycle -> grant order 0, 1. Reload both after the acks -> order 1, 0 is not produced; order follows the pointer (0 after 1's ack).
- Overflow: req_en[1] twice, with the slot busy on the second -> req_drop[1] one pulse, tx_number still equals the first payload. req_en[0] in the same cycle as its ack -> accepted, no drop.
- Reset mid-op: rst in WAIT_ACK -> next cycle all outputs 0, slots empty; a later tx_ready yields no req_done. The same sequence with interboard_rst gives an identical result.
- Retry (INTERBOARD_TX_RETRY_EN, TIMEOUT_CYC=8, MAX_RETRY=2): no tx_ready -> exactly 3 tx_en pulses 9 cycles apart, then req_drop[0] and the slot freed. Without the macro -> 1 tx_en, state holds WAIT_ACK.
- GAP_CYC=0: two queued messages, ack in cycle a -> second tx_en in cycle a+2.

Source files
------------

// File: rtl/interboard_tx_sched_pkg.sv
// Shared definitions for the interboard transmit scheduler: FSM state codes,
// requester indices, slot payload type and an index-width helper.
package interboard_tx_sched_pkg;

  localparam logic [1:0] TXS_IDLE     = 2'd0;
  localparam logic [1:0] TXS_ISSUE    = 2'd1;
  localparam logic [1:0] TXS_WAIT_ACK = 2'd2;
  localparam logic [1:0] TXS_GAP      = 2'd3;

  localparam int TXREQ_GAME = 0;
  localparam int TXREQ_MENU = 1;

  typedef struct packed {
    logic [2:0] msg_type;
    logic [4:0] number;
  } tx_msg_t;

  // Width needed to index n items, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/interboard_tx_sched_rr_arbiter.sv
// Combinational rotate-priority search: first valid index at or after ptr_i,
// wrapping modulo N.
module interboard_tx_sched_rr_arbiter
  import interboard_tx_sched_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] grant_o,
  output logic          any_valid_o
);

  int idx;

  // Walk from farthest to nearest so the nearest valid index wins.
  always_comb begin
    grant_o     = '0;
    any_valid_o = |valid_i;
    idx         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % N;
      if (valid_i[idx[IW-1:0]]) grant_o = idx[IW-1:0];
    end
  end

endmodule

// File: rtl/interboard_tx_sched.sv
// Round-robin scheduler for the single interboard transmit link.
// Optional timeout/retry build: define INTERBOARD_TX_RETRY_EN.
module interboard_tx_sched
  import interboard_tx_sched_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   interboard_rst,
  input  logic [NUM_REQ-1:0]     req_en,
  input  logic [3*NUM_REQ-1:0]   req_msg_type,
  input  logic [5*NUM_REQ-1:0]   req_number,
  output logic [NUM_REQ-1:0]     req_busy,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [NUM_REQ-1:0]     req_drop,
  output logic                   tx_en,
  output logic [2:0]             tx_msg_type,
  output logic [4:0]             tx_number,
  input  logic                   tx_ready,
  output logic [1:0]             dbg_state_o
);

  localparam int IW       = idx_width(NUM_REQ);
  localparam int GW       = idx_width(GAP_CYC + 1);
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  logic                srst;
  logic [1:0]          state_q, state_d;
  logic [NUM_REQ-1:0]  valid_q, valid_d;
  tx_msg_t             slot_q [NUM_REQ];
  tx_msg_t             slot_d [NUM_REQ];
  logic [IW-1:0]       gnt_q, gnt_d, ptr_q, ptr_d, arb_gnt;
  logic                arb_any;
  logic [GW-1:0]       gap_q, gap_d;
  logic [NUM_REQ-1:0]  done_q, done_d, drop_q, drop_d;
  logic                ack, abandon, sending;

`ifdef INTERBOARD_TX_RETRY_EN
  localparam int TW = idx_width(TIMEOUT_CYC);
  localparam int RW = idx_width(MAX_RETRY + 1);
  logic [TW-1:0] to_q, to_d;
  logic [RW-1:0] retry_q, retry_d;
`endif

  assign srst = rst | interboard_rst;

  interboard_tx_sched_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .valid_i     (valid_q),
    .ptr_i       (ptr_q),
    .grant_o     (arb_gnt),
    .any_valid_o (arb_any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    ack     = 1'b0;
    abandon = 1'b0;
`ifdef INTERBOARD_TX_RETRY_EN
    to_d    = to_q;
    retry_d = retry_q;
`endif
    case (state_q)
      TXS_IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_gnt;
          state_d = TXS_ISSUE;
`ifdef INTERBOARD_TX_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      TXS_ISSUE: begin
        state_d = TXS_WAIT_ACK;
`ifdef INTERBOARD_TX_RETRY_EN
        to_d    = '0;
`endif
      end
      TXS_WAIT_ACK: begin
        if (tx_ready) begin
          ack = 1'b1;
        end
`ifdef INTERBOARD_TX_RETRY_EN
        // An ack coinciding with the timeout wins over the retry.
        else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
          if (retry_q == RW'(MAX_RETRY)) begin
            abandon = 1'b1;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = TXS_ISSUE;
          end
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
        if (ack || abandon) begin
          ptr_d   = (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
          gap_d   = '0;
          state_d = (GAP_CYC > 0) ? TXS_GAP : TXS_IDLE;
        end
      end
      default: begin
        if (gap_q >= GW'(GAP_LAST)) state_d = TXS_IDLE;
        else                        gap_d   = gap_q + 1'b1;
      end
    endcase
  end

  // A slot being freed this cycle may be refilled in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      valid_d[i] = valid_q[i];
      slot_d[i]  = slot_q[i];
      done_d[i]  = ack && (gnt_q == IW'(i));
      drop_d[i]  = abandon && (gnt_q == IW'(i));
      if ((ack || abandon) && (gnt_q == IW'(i))) valid_d[i] = 1'b0;
      if (req_en[i]) begin
        if (!valid_d[i]) begin
          valid_d[i]          = 1'b1;
          slot_d[i].msg_type  = req_msg_type[3*i +: 3];
          slot_d[i].number    = req_number[5*i +: 5];
        end else begin
          drop_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= TXS_IDLE;
      valid_q <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      gap_q   <= '0;
      done_q  <= '0;
      drop_q  <= '0;
      for (int i = 0; i < NUM_REQ; i++) slot_q[i] <= '0;
`ifdef INTERBOARD_TX_RETRY_EN
      to_q    <= '0;
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      for (int i = 0; i < NUM_REQ; i++) slot_q[i] <= slot_d[i];
`ifdef INTERBOARD_TX_RETRY_EN
      to_q    <= to_d;
      retry_q <= retry_d;
`endif
    end
  end

  assign sending     = (state_q == TXS_ISSUE) || (state_q == TXS_WAIT_ACK);
  assign tx_en       = (state_q == TXS_ISSUE);
  assign tx_msg_type = sending ? slot_q[gnt_q].msg_type : 3'd0;
  assign tx_number   = sending ? slot_q[gnt_q].number   : 5'd0;
  assign req_busy    = valid_q;
  assign req_done    = done_q;
  assign req_drop    = drop_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_interboard_tx_sched.sv
// Directed bench for interboard_tx_sched: latency, round-robin order, overflow,
// reset abandonment, retry/timeout behaviour and zero-gap back-to-back issue.
module tb_interboard_tx_sched;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd2;
  // Stand-in message type codes.
  localparam logic [2:0] MSG_STATE_TURN = 3'd1;
  localparam logic [2:0] MSG_MENU       = 3'd3;

  logic       clk = 1'b0;
  logic       rst, ib_rst;
  logic [1:0] req_en, busy, done, drop;
  logic [5:0] req_type;
  logic [9:0] req_num;
  logic       tx_en, tx_ready;
  logic [2:0] tx_type;
  logic [4:0] tx_num;
  logic [1:0] dbg_state;

  logic [1:0] g0_req_en, g0_busy, g0_done, g0_drop, g0_state;
  logic [5:0] g0_req_type;
  logic [9:0] g0_req_num;
  logic       g0_tx_en, g0_tx_ready;
  logic [2:0] g0_tx_type;
  logic [4:0] g0_tx_num;

  int errors = 0;
  int checks = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  interboard_tx_sched #(.NUM_REQ(2), .GAP_CYC(4), .TIMEOUT_CYC(8), .MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst), .interboard_rst(ib_rst),
    .req_en(req_en), .req_msg_type(req_type), .req_number(req_num),
    .req_busy(busy), .req_done(done), .req_drop(drop),
    .tx_en(tx_en), .tx_msg_type(tx_type), .tx_number(tx_num),
    .tx_ready(tx_ready), .dbg_state_o(dbg_state)
  );

  interboard_tx_sched #(.NUM_REQ(2), .GAP_CYC(0), .TIMEOUT_CYC(8), .MAX_RETRY(2)) dut_g0 (
    .clk(clk), .rst(rst), .interboard_rst(1'b0),
    .req_en(g0_req_en), .req_msg_type(g0_req_type), .req_number(g0_req_num),
    .req_busy(g0_busy), .req_done(g0_done), .req_drop(g0_drop),
    .tx_en(g0_tx_en), .tx_msg_type(g0_tx_type), .tx_number(g0_tx_num),
    .tx_ready(g0_tx_ready), .dbg_state_o(g0_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic load(input logic [1:0] en, input logic [4:0] n0, input logic [4:0] n1);
    req_en   = en;
    req_type = {MSG_MENU, MSG_STATE_TURN};
    req_num  = {n1, n0};
    tick();
    req_en   = 2'b00;
  endtask

  task automatic ack_now();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (dbg_state !== S_IDLE && n < 20) begin
      tick();
      n++;
    end
    chk(tag, dbg_state, S_IDLE);
  endtask

  task automatic wait_tx(input string tag);
    int n = 0;
    while (tx_en !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    chk(tag, tx_en, 1'b1);
  endtask

  // Issue the next expected message, ack it, return to idle.
  task automatic expect_next(input string tag);
    logic [4:0] e;
    e = exp_q.pop_front();
    wait_tx({tag, "_en"});
    chk({tag, "_num"}, tx_num, e);
    tick();
    ack_now();
    wait_idle({tag, "_idle"});
  endtask

  task automatic reset_case(input bit use_ib, input string tag);
    load(2'b11, 5'd20, 5'd21);
    tick();
    tick();
    chk({tag, "_pre_state"}, dbg_state, S_WAIT);
    if (use_ib) ib_rst = 1'b1; else rst = 1'b1;
    tick();
    rst = 1'b0;
    ib_rst = 1'b0;
    chk({tag, "_outs"}, {tx_en, tx_type, tx_num, busy, done, drop, dbg_state}, 20'd0);
    ack_now();
    chk({tag, "_no_done"}, {done, drop}, 4'd0);
  endtask

  initial begin
    int t_en[$];
    int t_drop;

    rst = 1'b1; ib_rst = 1'b0; req_en = '0; req_type = '0; req_num = '0; tx_ready = 1'b0;
    g0_req_en = '0; g0_req_type = '0; g0_req_num = '0; g0_tx_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_outs", {tx_en, tx_type, tx_num, busy, done, drop, dbg_state}, 20'd0);

    // Single message: strobe in cycle t, tx_en in t+2, ack at t+10.
    req_type[2:0] = MSG_STATE_TURN;
    req_num[4:0]  = 5'd7;
    req_en = 2'b01;
    tick();
    req_en = 2'b00;
    chk("single_busy", busy, 2'b01);
    chk("single_no_en_yet", tx_en, 1'b0);
    tick();
    chk("single_en", tx_en, 1'b1);
    chk("single_type", tx_type, MSG_STATE_TURN);
    chk("single_num", tx_num, 5'd7);
    tick();
    chk("single_en_pulse", tx_en, 1'b0);
    chk("single_state_wait", dbg_state, S_WAIT);
    repeat (7) tick();
    chk("single_num_held", tx_num, 5'd7);
    ack_now();
    chk("single_done", done, 2'b01);
    chk("single_busy_clr", busy, 2'b00);
    // New message during the gap: tx_en exactly ack+GAP_CYC+2.
    req_en = 2'b10;
    req_num[9:5] = 5'd9;
    tick();
    req_en = 2'b00;
    chk("single_done_pulse", done, 2'b00);
    for (int k = 0; k < 4; k++) begin
      chk("gap_no_en", tx_en, 1'b0);
      tick();
    end
    chk("gap_en", tx_en, 1'b1);
    chk("gap_num", tx_num, 5'd9);
    tick();
    ack_now();
    chk("gap_done1", done, 2'b10);
    wait_idle("gap_idle");

    // Round robin: pointer at 0, both loaded -> 0 then 1.
    load(2'b11, 5'd1, 5'd2);
    exp_q.push_back(5'd1);
    exp_q.push_back(5'd2);
    expect_next("rr_a");
    expect_next("rr_b");
    // Pointer moves to 1 after slot 0 alone is served, so 1 wins next.
    load(2'b01, 5'd3, 5'd0);
    exp_q.push_back(5'd3);
    expect_next("rr_c");
    load(2'b11, 5'd4, 5'd5);
    exp_q.push_back(5'd5);
    exp_q.push_back(5'd4);
    expect_next("rr_d");
    expect_next("rr_e");

    // Overflow on slot 1, then refill in the same cycle as its ack.
    load(2'b10, 5'd0, 5'd12);
    req_en = 2'b10;
    req_num[9:5] = 5'd13;
    tick();
    req_en = 2'b00;
    chk("ovf_drop", drop, 2'b10);
    chk("ovf_en", tx_en, 1'b1);
    chk("ovf_num", tx_num, 5'd12);
    tick();
    chk("ovf_drop_pulse", drop, 2'b00);
    chk("ovf_num_held", tx_num, 5'd12);
    req_en = 2'b10;
    req_num[9:5] = 5'd14;
    tx_ready = 1'b1;
    tick();
    req_en = 2'b00;
    tx_ready = 1'b0;
    chk("same_cyc_done", done, 2'b10);
    chk("same_cyc_no_drop", drop, 2'b00);
    chk("same_cyc_busy", busy, 2'b10);
    wait_idle("same_cyc_idle");
    exp_q.push_back(5'd14);
    expect_next("same_cyc_issue");

    reset_case(1'b0, "rst");
    reset_case(1'b1, "ibrst");

    // Unacked message: log tx_en and drop over a fixed window.
    load(2'b01, 5'd22, 5'd0);
    t_drop = 0;
    for (int k = 1; k <= 35; k++) begin
      if (tx_en === 1'b1) t_en.push_back(k);
      if (drop[0] === 1'b1) t_drop = k;
      tick();
    end
`ifdef INTERBOARD_TX_RETRY_EN
    chk("retry_count", t_en.size(), 3);
    if (t_en.size() == 3) begin
      chk("retry_t0", t_en[0], 2);
      chk("retry_t1", t_en[1], 11);
      chk("retry_t2", t_en[2], 20);
    end
    chk("retry_drop_cyc", t_drop, 29);
    chk("retry_busy_clr", busy, 2'b00);
`else
    chk("noretry_count", t_en.size(), 1);
    if (t_en.size() == 1) chk("noretry_t0", t_en[0], 2);
    chk("noretry_no_drop", t_drop, 0);
    chk("noretry_state", dbg_state, S_WAIT);
    chk("noretry_busy", busy, 2'b01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif

    // Zero gap: ack in cycle a, next tx_en in a+2.
    g0_req_en = 2'b11;
    g0_req_type = {MSG_MENU, MSG_STATE_TURN};
    g0_req_num = {5'd2, 5'd1};
    tick();
    g0_req_en = 2'b00;
    begin
      int n = 0;
      while (g0_tx_en !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
    end
    chk("g0_first_en", g0_tx_en, 1'b1);
    chk("g0_first_num", g0_tx_num, 5'd1);
    tick();
    g0_tx_ready = 1'b1;
    tick();
    g0_tx_ready = 1'b0;
    chk("g0_no_en_a1", g0_tx_en, 1'b0);
    chk("g0_done", g0_done, 2'b01);
    tick();
    chk("g0_second_en", g0_tx_en, 1'b1);
    chk("g0_second_num", g0_tx_num, 5'd2);
    tick();
    g0_tx_ready = 1'b1;
    tick();
    g0_tx_ready = 1'b0;
    chk("g0_done2", g0_done, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
